fp_round_pipe: RTL and testbench

FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

---
 rtl/fp_pkg.sv | 62 ++++++
 rtl/fp_rnd_inc.sv | 15 +
 rtl/fp_round_pipe.sv | 125 ++++++++++++
 tb/tb_fp_round_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point types, format helpers and rounding increment
package fp_pkg;

   typedef enum logic [1:0] {FP32 = 2'd0, FP64 = 2'd1, FP16 = 2'd2} fp_format_e;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } roundmode_e;

   localparam int unsigned MAX_FP_WIDTH = 64;

   // u_result is sized for the widest format; narrower formats use the low bits
   typedef struct packed {
      logic [MAX_FP_WIDTH-1:0] u_result;
      logic [1:0]              rs;
      logic                    round_en;
      logic                    invalid;
      logic                    exp_cout;
   } uround_res_t;

   localparam int unsigned FLAG_NV = 4;
   localparam int unsigned FLAG_DZ = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   function automatic int unsigned exp_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 11;
         FP16:    return 5;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned man_bits(fp_format_e fmt);
      case (fmt)
         FP64:    return 52;
         FP16:    return 10;
         default: return 23;
      endcase
   endfunction

   function automatic int unsigned fp_width(fp_format_e fmt);
      return 1 + exp_bits(fmt) + man_bits(fmt);
   endfunction

   function automatic logic rnd_inc(logic r, logic s, logic lsb, logic sign, roundmode_e mode);
      case (mode)
         RNE:     return r & (s | lsb);
         RTZ:     return 1'b0;
         RDN:     return (r | s) & sign;
         RUP:     return (r | s) & ~sign;
         RMM:     return r;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/fp_rnd_inc.sv
// rtl/fp_rnd_inc.sv - combinational round-increment decode from guard/sticky/lsb/sign
module fp_rnd_inc
   import fp_pkg::*;
(
   input  logic       r,
   input  logic       s,
   input  logic       lsb,
   input  logic       sign,
   input  roundmode_e mode,
   output logic       inc
);

   assign inc = rnd_inc(r, s, lsb, sign, mode);

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage valid/ready rounding pipeline with IEEE flag generation
module fp_round_pipe
   import fp_pkg::*;
#(
   parameter  fp_format_e  FP_FORMAT  = FP32,
   localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT),
   localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT),
   localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT)
)(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                valid_i,
   output logic                ready_o,
   input  uround_res_t         urnd_i,
   input  roundmode_e          rnd_i,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [FP_WIDTH-1:0] result_o,
   output logic [4:0]          fflags_o
);

   localparam int unsigned EM_WIDTH = EXP_WIDTH + MANT_WIDTH;

   logic                s1_valid, s2_valid, s1_en, s2_en;
   logic                inc_d;
   logic [FP_WIDTH-1:0] s1_u;
   logic [1:0]          s1_rs;
   logic                s1_ren, s1_inv, s1_cout, s1_inc;
   roundmode_e          s1_rnd;
   logic [FP_WIDTH-1:0] s2_result;
   logic [4:0]          s2_flags;
   logic                unused_urnd;

   assign unused_urnd = ^urnd_i.u_result;

   assign s2_en   = ~s2_valid | ready_i;
   assign s1_en   = ~s1_valid | s2_en;
   assign ready_o = s1_en;

   fp_rnd_inc u_rnd_inc (
      .r    (urnd_i.rs[1]),
      .s    (urnd_i.rs[0]),
      .lsb  (urnd_i.u_result[0]),
      .sign (urnd_i.u_result[FP_WIDTH-1]),
      .mode (rnd_i),
      .inc  (inc_d)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid <= 1'b0;
      end else if (s1_en) begin
         s1_valid <= valid_i;
         if (valid_i) begin
            s1_u    <= urnd_i.u_result[FP_WIDTH-1:0];
            s1_rs   <= urnd_i.rs;
            s1_ren  <= urnd_i.round_en;
            s1_inv  <= urnd_i.invalid;
            s1_cout <= urnd_i.exp_cout;
            s1_inc  <= inc_d;
            s1_rnd  <= rnd_i;
         end
      end
   end

   logic                 sign, finite, ovf, to_inf, nx;
   logic [EM_WIDTH-1:0]  em, sum, ovf_sum;
   logic [EXP_WIDTH-1:0] exp_in;
   logic [FP_WIDTH-1:0]  res_d;
   logic [4:0]           flags_d;

   assign sign    = s1_u[FP_WIDTH-1];
   assign em      = s1_u[EM_WIDTH-1:0];
   assign exp_in  = em[EM_WIDTH-1:MANT_WIDTH];
   assign finite  = ~&exp_in;
   assign sum     = em + EM_WIDTH'(s1_inc);
   // Overflow is judged on the magnitude rounded up whenever the guard bit is set,
   // so truncating modes still flag it and saturate to max finite.
   assign ovf_sum = em + EM_WIDTH'(s1_inc | s1_rs[1]);
   assign ovf     = s1_cout | (finite & (&ovf_sum[EM_WIDTH-1:MANT_WIDTH]));

   always_comb begin
      res_d            = s1_u;
      flags_d          = '0;
      flags_d[FLAG_NV] = s1_inv;
      to_inf           = 1'b0;
      nx               = 1'b0;
      if (s1_ren) begin
         res_d = {sign, sum};
         nx    = s1_rs[1] | s1_rs[0] | ovf;
         if (ovf) begin
            case (s1_rnd)
               RNE, RMM: to_inf = 1'b1;
               RUP:      to_inf = ~sign;
               RDN:      to_inf = sign;
               default:  to_inf = 1'b0;
            endcase
            res_d = to_inf ? {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}}
                           : {sign, {{(EXP_WIDTH-1){1'b1}}, 1'b0}, {MANT_WIDTH{1'b1}}};
         end
         flags_d[FLAG_OF] = ovf;
         flags_d[FLAG_UF] = nx & (exp_in == '0);
         flags_d[FLAG_NX] = nx;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_flags  <= '0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= res_d;
            s2_flags  <= flags_d;
         end
      end
   end

   assign valid_o  = s2_valid;
   assign result_o = s2_result;
   assign fflags_o = s2_flags;

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - randomized scoreboard bench for fp_round_pipe (FP32)
module tb_fp_round_pipe;
   import fp_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_i = 1'b0;
   logic        ready_o, valid_o;
   uround_res_t urnd_i = '0;
   roundmode_e  rnd_i = RNE;
   logic [31:0] result_o;
   logic [4:0]  fflags_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   fp_round_pipe #(.FP_FORMAT(FP32)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .urnd_i   (urnd_i),
      .rnd_i    (rnd_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o),
      .fflags_o (fflags_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: rounding on the unsigned magnitude as a plain integer, flags {NV,DZ,OF,UF,NX}
   function automatic logic [36:0] model(input logic [31:0] u, input logic [1:0] rs,
                                         input bit ren, input bit inv, input bit cout,
                                         input roundmode_e m);
      int unsigned mag, lim;
      bit sign, r, s, inc, ovf, up, nx, uf;
      logic [31:0] res;
      if (!ren) return {inv, 4'b0000, u};
      sign = u[31];
      mag  = {1'b0, u[30:0]};
      lim  = 32'h7F80_0000;
      r = rs[1];
      s = rs[0];
      case (m)
         RNE:     inc = r && (s || mag[0]);
         RDN:     inc = (r || s) && sign;
         RUP:     inc = (r || s) && !sign;
         RMM:     inc = r;
         default: inc = 0;
      endcase
      ovf = cout || (mag < lim && (mag + inc >= lim || mag + r >= lim));
      if (ovf) begin
         up  = (m == RNE) || (m == RMM) || (m == RUP && !sign) || (m == RDN && sign);
         res = {sign, up ? 31'h7F80_0000 : 31'h7F7F_FFFF};
      end else begin
         res = {sign, 31'(mag + inc)};
      end
      nx = r || s || ovf;
      uf = nx && (mag < 32'h0080_0000);
      return {inv, 1'b0, ovf, uf, nx, res};
   endfunction

   task automatic drive(input logic [31:0] u, input logic [1:0] rs, input bit ren,
                        input bit inv, input bit cout, input roundmode_e m);
      urnd_i          = '0;
      urnd_i.u_result = {32'h0, u};
      urnd_i.rs       = rs;
      urnd_i.round_en = ren;
      urnd_i.invalid  = inv;
      urnd_i.exp_cout = cout;
      rnd_i           = m;
   endtask

   task automatic rand_beat(output logic [36:0] exp);
      logic [31:0] u;
      logic [1:0]  rs;
      bit          ren, inv, cout;
      roundmode_e  m;
      u = $urandom;
      case ($urandom_range(0, 3))
         0: u[30:0] = 31'h7F7F_FFFF - 31'($urandom_range(0, 1));
         1: u[30:23] = 8'h00;
         default: ;
      endcase
      if (u[30:23] == 8'hFF) u[30] = 1'b0;
      rs   = 2'($urandom_range(0, 3));
      ren  = $urandom_range(0, 7) != 0;
      inv  = $urandom_range(0, 7) == 0;
      cout = $urandom_range(0, 15) == 0;
      m    = roundmode_e'($urandom_range(0, 4));
      drive(u, rs, ren, inv, cout, m);
      exp = model(u, rs, ren, inv, cout, m);
   endtask

   task automatic directed(input string tag, input logic [31:0] u, input logic [1:0] rs,
                           input bit ren, input bit inv, input roundmode_e m,
                           input logic [31:0] er, input logic [4:0] ef);
      @(negedge clk_i);
      drive(u, rs, ren, inv, 1'b0, m);
      valid_i = 1'b1;
      ready_i = 1'b1;
      #1 check({tag, "_ready"}, ready_o, 1'b1);
      @(negedge clk_i);
      valid_i = 1'b0;
      #1 check({tag, "_lat1"}, valid_o, 1'b0);
      @(negedge clk_i);
      #1 check({tag, "_lat2"}, valid_o, 1'b1);
      check({tag, "_result"}, result_o, er);
      check({tag, "_flags"}, fflags_o, ef);
   endtask

   task automatic run_stream(input string tag, input int n, input bit pattern, input int gap_pct);
      logic [36:0] q[$];
      logic [36:0] cur, e;
      logic [31:0] hres;
      logic [4:0]  hfl;
      int sent = 0, got = 0, cyc = 0;
      bit hold = 0, pend = 0;
      while ((sent < n || got < n) && cyc < 3000) begin
         @(negedge clk_i);
         if (!pend) begin
            if (sent < n && $urandom_range(0, 99) >= gap_pct) begin
               rand_beat(cur);
               valid_i = 1'b1;
            end else begin
               valid_i = 1'b0;
            end
         end
         ready_i = pattern ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
         cyc++;
         #1;
         if (hold) begin
            check({tag, "_hold_valid"}, valid_o, 1'b1);
            check({tag, "_hold_result"}, result_o, hres);
            check({tag, "_hold_flags"}, fflags_o, hfl);
         end
         if (valid_o && ready_i) begin
            if (q.size() == 0) begin
               check({tag, "_spurious_beat"}, valid_o, 1'b0);
            end else begin
               e = q.pop_front();
               check({tag, "_result"}, result_o, e[31:0]);
               check({tag, "_flags"}, fflags_o, e[36:32]);
               got++;
            end
         end
         hold = valid_o && !ready_i;
         hres = result_o;
         hfl  = fflags_o;
         if (valid_i && ready_o) begin
            q.push_back(cur);
            sent++;
            pend = 0;
         end else begin
            pend = valid_i;
         end
      end
      check({tag, "_delivered"}, got, n);
      check({tag, "_leftover"}, q.size(), 0);
      @(negedge clk_i);
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
   endtask

   initial begin
      drive(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, RNE);
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_valid_o", valid_o, 1'b0);
      check("rst_ready_o", ready_o, 1'b1);
      check("rst_result", result_o, 32'h0);
      check("rst_flags", fflags_o, 5'h0);
      rst_ni = 1'b1;

      directed("rne_up",      32'h3F80_0001, 2'b11, 1, 0, RNE, 32'h3F80_0002, 5'b00001);
      directed("rne_tie",     32'h3F80_0000, 2'b10, 1, 0, RNE, 32'h3F80_0000, 5'b00001);
      directed("rne_ovf",     32'h7F7F_FFFF, 2'b11, 1, 0, RNE, 32'h7F80_0000, 5'b00101);
      directed("rtz_ovf",     32'h7F7F_FFFF, 2'b11, 1, 0, RTZ, 32'h7F7F_FFFF, 5'b00101);
      directed("rdn_tiny",    32'h0000_0001, 2'b01, 1, 0, RDN, 32'h0000_0001, 5'b00011);
      directed("rdn_neg_ovf", 32'hFF7F_FFFF, 2'b01, 1, 0, RDN, 32'hFF80_0000, 5'b00101);
      directed("rup_neg_max", 32'hFF7F_FFFF, 2'b01, 1, 0, RUP, 32'hFF7F_FFFF, 5'b00001);
      directed("bypass_nv",   32'hDEAD_BEEF, 2'b11, 0, 1, RUP, 32'hDEAD_BEEF, 5'b10000);

      run_stream("b2b8", 8, 1'b1, 0);
      run_stream("rand", 300, 1'b0, 25);

      // two beats in flight, then reset
      @(negedge clk_i);
      ready_i = 1'b0;
      drive(32'h3F80_0001, 2'b11, 1'b1, 1'b0, 1'b0, RNE);
      valid_i = 1'b1;
      @(negedge clk_i);
      drive(32'h4000_0000, 2'b01, 1'b1, 1'b0, 1'b0, RUP);
      #1 check("inflight_ready", ready_o, 1'b1);
      @(negedge clk_i);
      valid_i = 1'b0;
      #1 check("inflight_valid", valid_o, 1'b1);
      rst_ni = 1'b0;
      @(negedge clk_i);
      #1;
      check("rst2_valid_o", valid_o, 1'b0);
      check("rst2_ready_o", ready_o, 1'b1);
      check("rst2_result", result_o, 32'h0);
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      @(negedge clk_i);
      #1;
      check("post_rst_valid_o", valid_o, 1'b0);
      check("post_rst_ready_o", ready_o, 1'b1);
      check("post_rst_result", result_o, 32'h0);
      check("post_rst_flags", fflags_o, 5'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         #1 check("no_ghost_beat", valid_o, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
